// File: rtl/pipeline_hazard_controller_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller_if
// Bundles the pipeline-side signals of the hazard controller.
//   master : pipeline / stage logic. Drives the ID sources, the EX/MEM
//            destinations, the branch outcome and the memory handshake.
//            Receives the freeze/flush controls and the debug counters.
//   slave  : pipeline_hazard_controller. Sees the same signals with the
//            directions reversed.
// Parameter CNT_WIDTH sets the width of the performance counters.
// -----------------------------------------------------------------------------
interface pipeline_hazard_controller_if #(
  parameter int CNT_WIDTH = 16
);
  // ID-stage sources
  logic [3:0]           idSrc1;
  logic [3:0]           idSrc2;
  logic                 idSrc1Valid;
  logic                 idSrc2Valid;
  // EX / MEM destinations
  logic [3:0]           exDestination;
  logic                 exWriteBackEnabled;
  logic                 exMemoryReadEnabled;
  logic [3:0]           memDestination;
  logic                 memWriteBackEnabled;
  // Branch outcome and data-memory handshake
  logic                 exBranchTaken;
  logic                 memAccessStart;
  logic                 memReady;
  // Stage controls
  logic                 freezePc;
  logic                 freezeIfReg;
  logic                 freezeIdReg;
  logic                 freezeExReg;
  logic                 freezeMemReg;
  logic                 flushIfReg;
  logic                 flushIdReg;
  // Status and performance counters
  logic                 memTimeout;
  logic [CNT_WIDTH-1:0] stallCycles;
  logic [CNT_WIDTH-1:0] flushCount;

  modport master (
    output idSrc1, idSrc2, idSrc1Valid, idSrc2Valid,
           exDestination, exWriteBackEnabled, exMemoryReadEnabled,
           memDestination, memWriteBackEnabled,
           exBranchTaken, memAccessStart, memReady,
    input  freezePc, freezeIfReg, freezeIdReg, freezeExReg, freezeMemReg,
           flushIfReg, flushIdReg, memTimeout, stallCycles, flushCount
  );

  modport slave (
    input  idSrc1, idSrc2, idSrc1Valid, idSrc2Valid,
           exDestination, exWriteBackEnabled, exMemoryReadEnabled,
           memDestination, memWriteBackEnabled,
           exBranchTaken, memAccessStart, memReady,
    output freezePc, freezeIfReg, freezeIdReg, freezeExReg, freezeMemReg,
           flushIfReg, flushIdReg, memTimeout, stallCycles, flushCount
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
// Central stall/flush sequencer for the five-stage pipeline. Each cycle it
// decides which stage registers are frozen and which receive a bubble. The
// decision comes from RAW hazards, taken branches and the multi-cycle data
// memory. It also keeps saturating stall/flush counters for debug.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : pipeline_hazard_controller_if.slave (sources, destinations,
//          branch, memory handshake in; freezes, flushes, timeout flag,
//          counters out)
// Parameters:
//   FORWARDING  : 1 = only load-use hazards stall, 0 = any RAW vs EX/MEM
//   MEM_TIMEOUT : memory wait cycles tolerated before ERROR (>= 1)
//   CNT_WIDTH   : performance counter width
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter bit FORWARDING  = 1'b1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  pipeline_hazard_controller_if.slave   bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]    WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [CNT_WIDTH-1:0] stall_q, flush_q;
  logic                 timeout_q;

  // ---------------------------------------------------------------------------
  // Hazard detection, one comparator pair per ID source.
  // ---------------------------------------------------------------------------
  logic [3:0] src   [2];
  logic       src_v [2];
  logic [1:0] hit;
  logic       hazard;

  assign src[0]   = bus.idSrc1;
  assign src[1]   = bus.idSrc2;
  assign src_v[0] = bus.idSrc1Valid;
  assign src_v[1] = bus.idSrc2Valid;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    if (FORWARDING) begin : g_fwd
      // With forwarding, only a load in EX cannot supply its result in time.
      assign hit[gi] = src_v[gi] && bus.exWriteBackEnabled &&
                       bus.exMemoryReadEnabled && (bus.exDestination == src[gi]);
    end else begin : g_nofwd
      assign hit[gi] = src_v[gi] &&
                       ((bus.exWriteBackEnabled  && (bus.exDestination  == src[gi])) ||
                        (bus.memWriteBackEnabled && (bus.memDestination == src[gi])));
    end
  end

  assign hazard = |hit;

  // ---------------------------------------------------------------------------
  // Next-state and Mealy control decode
  // ---------------------------------------------------------------------------
  logic freeze_all;    // all five freezes
  logic freeze_front;  // PC and IF/ID only (hazard stall)
  logic flush_if;
  logic flush_id;

  always_comb begin
    freeze_all   = 1'b0;
    freeze_front = 1'b0;
    flush_if     = 1'b0;
    flush_id     = 1'b0;
    state_d      = state_q;
    wait_d       = wait_q;
    case (state_q)
      RUN: begin
        if (bus.memAccessStart && !bus.memReady) begin
          freeze_all = 1'b1;
          state_d    = MEM_WAIT;
          wait_d     = WAIT_W'(1);
        end else if (bus.exBranchTaken) begin
          // The ID instruction is discarded, so any hazard on it is moot.
          flush_if = 1'b1;
          flush_id = 1'b1;
        end else if (hazard) begin
          freeze_front = 1'b1;
          flush_id     = 1'b1;   // bubble into EX
        end
      end
      MEM_WAIT: begin
        // Branch/hazard inputs are frozen too and get re-evaluated afterwards.
        freeze_all = 1'b1;
        if (bus.memReady) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ERROR: begin
        freeze_all = 1'b1;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  logic freeze_pc_int;
  assign freeze_pc_int = freeze_all | freeze_front;

  // ---------------------------------------------------------------------------
  // State, wait counter and saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= (state_d == ERROR);
      if (freeze_pc_int && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush_if && (flush_q != CNT_MAX)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: controls are forced low for as long as reset is held.
  // ---------------------------------------------------------------------------
  assign bus.freezePc     = rst & freeze_pc_int;
  assign bus.freezeIfReg  = rst & freeze_pc_int;
  assign bus.freezeIdReg  = rst & freeze_all;
  assign bus.freezeExReg  = rst & freeze_all;
  assign bus.freezeMemReg = rst & freeze_all;
  assign bus.flushIfReg   = rst & flush_if;
  assign bus.flushIdReg   = rst & flush_id;
  assign bus.memTimeout   = timeout_q;
  assign bus.stallCycles  = stall_q;
  assign bus.flushCount   = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_controller
// Drives two controllers with identical stimulus:
//   dut_f : FORWARDING=1, MEM_TIMEOUT=4, CNT_WIDTH=4
//   dut_n : FORWARDING=0, MEM_TIMEOUT=6, CNT_WIDTH=16
// Each one is compared every cycle against a cycle-count reference model.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  logic [3:0] in_src1 = '0, in_src2 = '0, in_exd = '0, in_memd = '0;
  logic in_v1 = 0, in_v2 = 0, in_exwb = 0, in_exmr = 0, in_memwb = 0;
  logic in_br = 0, in_start = 0, in_ready = 0;

  pipeline_hazard_controller_if #(.CNT_WIDTH(4))  if_f ();
  pipeline_hazard_controller_if #(.CNT_WIDTH(16)) if_n ();

  assign if_f.idSrc1 = in_src1;              assign if_n.idSrc1 = in_src1;
  assign if_f.idSrc2 = in_src2;              assign if_n.idSrc2 = in_src2;
  assign if_f.idSrc1Valid = in_v1;           assign if_n.idSrc1Valid = in_v1;
  assign if_f.idSrc2Valid = in_v2;           assign if_n.idSrc2Valid = in_v2;
  assign if_f.exDestination = in_exd;        assign if_n.exDestination = in_exd;
  assign if_f.exWriteBackEnabled = in_exwb;  assign if_n.exWriteBackEnabled = in_exwb;
  assign if_f.exMemoryReadEnabled = in_exmr; assign if_n.exMemoryReadEnabled = in_exmr;
  assign if_f.memDestination = in_memd;      assign if_n.memDestination = in_memd;
  assign if_f.memWriteBackEnabled = in_memwb; assign if_n.memWriteBackEnabled = in_memwb;
  assign if_f.exBranchTaken = in_br;         assign if_n.exBranchTaken = in_br;
  assign if_f.memAccessStart = in_start;     assign if_n.memAccessStart = in_start;
  assign if_f.memReady = in_ready;           assign if_n.memReady = in_ready;

  pipeline_hazard_controller #(.FORWARDING(1'b1), .MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut_f (
    .clk(clk), .rst(rst), .bus(if_f.slave)
  );
  pipeline_hazard_controller #(.FORWARDING(1'b0), .MEM_TIMEOUT(6), .CNT_WIDTH(16)) dut_n (
    .clk(clk), .rst(rst), .bus(if_n.slave)
  );

  // Observed outputs: {freezePc,freezeIf,freezeId,freezeEx,freezeMem,flushIf,flushId,memTimeout}
  logic [7:0]  obs_out   [2];
  logic [31:0] obs_stall [2];
  logic [31:0] obs_flush [2];
  assign obs_out[0] = {if_f.freezePc, if_f.freezeIfReg, if_f.freezeIdReg, if_f.freezeExReg,
                       if_f.freezeMemReg, if_f.flushIfReg, if_f.flushIdReg, if_f.memTimeout};
  assign obs_out[1] = {if_n.freezePc, if_n.freezeIfReg, if_n.freezeIdReg, if_n.freezeExReg,
                       if_n.freezeMemReg, if_n.flushIfReg, if_n.flushIdReg, if_n.memTimeout};
  assign obs_stall[0] = 32'(if_f.stallCycles);
  assign obs_stall[1] = 32'(if_n.stallCycles);
  assign obs_flush[0] = 32'(if_f.flushCount);
  assign obs_flush[1] = 32'(if_n.flushCount);

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks "in a memory wait, on frozen cycle k" rather than
  // a state register. Counters are plain integers clamped at 2**W-1.
  // ---------------------------------------------------------------------------
  localparam int M_FWD [2] = '{1, 0};
  localparam int M_TMO [2] = '{4, 6};
  localparam int M_CW  [2] = '{4, 16};

  bit m_wait [2];
  int m_k    [2];   // index of the current frozen cycle, start cycle = 1
  bit m_err  [2];
  int m_stall[2];
  int m_flush[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wait[i] = 0; m_k[i] = 0; m_err[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
    end
  endfunction

  function automatic bit src_hits(int i, logic [3:0] r);
    if (M_FWD[i] != 0) return in_exwb && in_exmr && (in_exd == r);
    return (in_exwb && (in_exd == r)) || (in_memwb && (in_memd == r));
  endfunction

  function automatic logic [7:0] expect_out(int i);
    bit hz;
    hz = (in_v1 && src_hits(i, in_src1)) || (in_v2 && src_hits(i, in_src2));
    if (!rst)                    return 8'b0000_0000 | {7'b0, m_err[i]};
    if (m_err[i])                return 8'b1111_1001;
    if (m_wait[i])               return 8'b1111_1000;
    if (in_start && !in_ready)   return 8'b1111_1000;
    if (in_br)                   return 8'b0000_0110;
    if (hz)                      return 8'b1100_0010;
    return 8'b0000_0000;
  endfunction

  function automatic int sat_inc(int v, int w);
    return (v < (1 << w) - 1) ? v + 1 : v;
  endfunction

  // One clock cycle. Called just after a falling edge with inputs settled.
  task automatic step(string tag);
    logic [7:0] e [2];
    #1;
    if (!rst) model_reset();
    for (int i = 0; i < 2; i++) begin
      e[i] = expect_out(i);
      check_eq($sformatf("%s/%s/ctl", tag, i == 0 ? "f" : "n"), 32'(obs_out[i]), 32'(e[i]));
      check_eq($sformatf("%s/%s/stall", tag, i == 0 ? "f" : "n"), obs_stall[i], 32'(m_stall[i]));
      check_eq($sformatf("%s/%s/flush", tag, i == 0 ? "f" : "n"), obs_flush[i], 32'(m_flush[i]));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        if (e[i][7]) m_stall[i] = sat_inc(m_stall[i], M_CW[i]);
        if (e[i][2]) m_flush[i] = sat_inc(m_flush[i], M_CW[i]);
        if (m_err[i]) begin
          // stays until reset
        end else if (m_wait[i]) begin
          if (in_ready)                   m_wait[i] = 0;
          else if (m_k[i] == M_TMO[i] + 1) begin m_wait[i] = 0; m_err[i] = 1; end
          else                            m_k[i]++;
        end else if (in_start && !in_ready) begin
          m_wait[i] = 1;
          m_k[i]    = 2;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    in_src1 = 0; in_src2 = 0; in_exd = 0; in_memd = 0;
    in_v1 = 0; in_v2 = 0; in_exwb = 0; in_exmr = 0; in_memwb = 0;
    in_br = 0; in_start = 0; in_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step("reset");
    step("reset");
    rst = 1'b1;
  endtask

  task automatic set_load_use();
    in_src1 = 4'd3; in_v1 = 1; in_exd = 4'd3; in_exwb = 1; in_exmr = 1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    clear_inputs();
    @(negedge clk);
    do_reset();

    // Load-use hazard, then EX holds the bubble
    set_load_use();
    step("loaduse");
    in_exwb = 0; in_exmr = 0;
    step("bubble");
    check_eq("loaduse_stall_cnt", obs_stall[0], 32'd1);

    // MEM-only RAW hazard: stalls without forwarding, not with it
    do_reset();
    clear_inputs();
    in_src2 = 4'd5; in_v2 = 1; in_memd = 4'd5; in_memwb = 1; in_exd = 4'd7; in_exwb = 1;
    step("memraw");
    check_eq("memraw_stall_f", obs_stall[0], 32'd0);
    check_eq("memraw_stall_n", obs_stall[1], 32'd1);

    // Branch wins over a simultaneous load-use hazard
    clear_inputs();
    set_load_use();
    in_br = 1;
    step("branch");
    check_eq("branch_flush_cnt", obs_flush[0], 32'd1);
    check_eq("branch_stall_cnt", obs_stall[0], 32'd0);

    // Memory access completing two cycles after start; branch ignored meanwhile
    do_reset();
    clear_inputs();
    in_start = 1;
    step("mem_start");
    in_start = 0; in_br = 1;
    step("mem_wait_br");
    in_br = 0; in_ready = 1;
    step("mem_ready");
    in_ready = 0;
    step("mem_after");
    check_eq("mem_stall_cnt", obs_stall[0], 32'd3);
    check_eq("mem_flush_cnt", obs_flush[0], 32'd0);

    // Timeout: dut_f errors after 5 frozen cycles, dut_n after 7
    do_reset();
    clear_inputs();
    in_start = 1;
    step("tmo_start");
    in_start = 0;
    for (int c = 0; c < 8; c++) step($sformatf("tmo_%0d", c));
    check_eq("tmo_flag_f", 32'(obs_out[0][0]), 32'd1);
    check_eq("tmo_flag_n", 32'(obs_out[1][0]), 32'd1);
    // Asynchronous clear in the middle of a low clock phase
    rst = 1'b0;
    #1;
    check_eq("async_clr_ctl_f", 32'(obs_out[0]), 32'd0);
    check_eq("async_clr_stall_f", obs_stall[0], 32'd0);
    @(negedge clk);
    step("tmo_rst");
    rst = 1'b1;

    // Counter saturation on the 4-bit instance
    set_load_use();
    for (int c = 0; c < 20; c++) step("sat");
    check_eq("sat_stall_f", obs_stall[0], 32'd15);
    check_eq("sat_stall_n", obs_stall[1], 32'd20);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_src1  = 4'($urandom_range(0, 3));
      in_src2  = 4'($urandom_range(0, 3));
      in_exd   = 4'($urandom_range(0, 3));
      in_memd  = 4'($urandom_range(0, 3));
      in_v1    = 1'($urandom_range(0, 1));
      in_v2    = 1'($urandom_range(0, 1));
      in_exwb  = 1'($urandom_range(0, 1));
      in_exmr  = 1'($urandom_range(0, 1));
      in_memwb = 1'($urandom_range(0, 1));
      in_br    = ($urandom_range(0, 5) == 0);
      in_start = ($urandom_range(0, 7) == 0);
      in_ready = ($urandom_range(0, 2) == 0);
      if (!rst)                              rst = 1'b1;
      else if ($urandom_range(0, 120) == 0)  rst = 1'b0;
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the five-stage ARM pipeline. Each cycle it decides which stage registers are frozen and which are flushed, from four inputs: the ID-stage source registers, the EX/MEM destinations, the branch outcome from EX and the handshake of the multi-cycle data memory. It replaces the constant freeze/flush ties on the IF/ID, ID/EX, EX/MEM stage registers and the PC. It also keeps saturating stall and flush counters for performance debug.

## Interface
- FORWARDING, 1, 1 = forwarding unit present (only load-use hazards stall); 0 = stall on any RAW hazard against EX or MEM
- MEM_TIMEOUT, 255, max MEM_WAIT cycles tolerated before the ERROR state (≥1)
- CNT_WIDTH, 16, width of the performance counters
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- idSrc1, idSrc2  in  4  source register numbers of the instruction in ID
- idSrc1Valid, idSrc2Valid  in  1  source actually read
- exDestination  in  4  destination of the instruction in EX
- exWriteBackEnabled, exMemoryReadEnabled  in  1  EX control bits
- memDestination  in  4  destination of the instruction in MEM
- memWriteBackEnabled  in  1  MEM write-back bit
- exBranchTaken  in  1  branch resolved taken in EX this cycle
- memAccessStart  in  1  MEM stage issues a data-memory access this cycle
- memReady  in  1  data memory completes the access this cycle
- freezePc, freezeIfReg, freezeIdReg, freezeExReg, freezeMemReg  out  1  hold the PC / stage register
- flushIfReg, flushIdReg  out  1  load a bubble into the IF/ID or ID/EX register
- memTimeout  out  1  sticky error flag
- stallCycles, flushCount  out  CNT_WIDTH  performance counters

## Operation
- Hazard term, combinational. For FORWARDING=0, a source Sx hits when it is valid and (exWriteBackEnabled and exDestination==Sx, or memWriteBackEnabled and memDestination==Sx). For FORWARDING=1, a source Sx hits only when it is valid and exWriteBackEnabled, exMemoryReadEnabled and exDestination==Sx. hazard = hit on src1 OR hit on src2.
- States: RUN, MEM_WAIT, ERROR. Outputs are Mealy, derived from the state plus the current inputs.
- RUN, priority order:
  - (1) memAccessStart and not memReady: all five freezes = 1, flushes = 0, next state MEM_WAIT, waitCount <= 1.
  - (2) exBranchTaken: flushIfReg = flushIdReg = 1, no freeze. A simultaneous hazard is ignored because the ID instruction is discarded.
  - (3) hazard: freezePc = freezeIfReg = 1, flushIdReg = 1 (bubble into EX), all other outputs 0.
  - (4) Otherwise all outputs 0.
  - memAccessStart together with memReady completes in one cycle with no stall.
- MEM_WAIT:
  - All five freezes = 1. Flushes = 0. Branch and hazard inputs are ignored, because they are frozen and re-evaluated after the stall.
  - memReady: freezes still 1 this cycle, next state RUN.
  - Else if waitCount == MEM_TIMEOUT: next state ERROR.
  - Else waitCount++.
- ERROR: all freezes = 1, flushes = 0, memTimeout = 1. Exited only by reset.
- stallCycles increments by 1 in every cycle in which freezePc = 1; it saturates at all-ones.
- flushCount increments in every cycle in which flushIfReg = 1; it saturates.
- waitCount is internal and ceil(log2(MEM_TIMEOUT+1)) bits wide.

## Timing
- Reset (rst = 0, asynchronous): state RUN, waitCount 0, stallCycles 0, flushCount 0, memTimeout 0. All freeze/flush outputs are forced to 0 while rst = 0, regardless of the inputs.
- Hazard and branch responses are combinational, in the same cycle as the triggering inputs, with zero latency.
- A memory stall lasts from the start cycle through the cycle in which memReady is seen. A ready arriving N cycles after start gives N+1 frozen cycles.
- Timeout: with no memReady, ERROR is entered at the edge ending frozen cycle MEM_TIMEOUT+1, counting the start cycle.
- Reset mid-MEM_WAIT or mid-ERROR: outputs drop to 0 immediately and the block returns to RUN.
- memReady in RUN without memAccessStart is ignored.

## Test plan
- FORWARDING=1, idSrc1 = 3 valid, exDestination = 3, exWriteBackEnabled = exMemoryReadEnabled = 1 → same cycle freezePc = freezeIfReg = flushIdReg = 1. The next cycle, with EX now holding the bubble, all outputs are 0. stallCycles = 1.
- FORWARDING=0, idSrc2 = 5 valid, memDestination = 5, memWriteBackEnabled = 1, no EX match → stall as above. The same case with FORWARDING=1 → no stall.
- exBranchTaken = 1 together with a load-use hazard → flushIfReg = flushIdReg = 1, freezePc = 0, flushCount = 1, stallCycles unchanged.
- memAccessStart = 1 with memReady low, then memReady = 1 two cycles later → freezes high for 3 cycles, state back to RUN, stallCycles = 3. A branch asserted during the wait produces no flush.
- MEM_TIMEOUT = 4, memAccessStart with memReady never asserted → 5 frozen cycles, then ERROR with memTimeout = 1 and freezes held. Asserting rst low clears everything asynchronously.
- CNT_WIDTH = 4 with 20 consecutive hazard cycles → stallCycles saturates at 15.
